// File: rtl/alu_share_arbiter.sv
// Shares one 8-bit ALU between two requesters: valid/ready accept, settle wait, one-cycle response.
// Optional define ALU_SHARE_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties) instead of round-robin.
module alu_share_arbiter #(
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ_VALID0,
   input  logic       REQ_VALID1,
   output logic       REQ_READY0,
   output logic       REQ_READY1,
   input  logic [7:0] REQ_DATA1_0,
   input  logic [7:0] REQ_DATA2_0,
   input  logic [2:0] REQ_SELECT_0,
   input  logic       REQ_R_0,
   input  logic [1:0] REQ_RS_0,
   input  logic [7:0] REQ_DATA1_1,
   input  logic [7:0] REQ_DATA2_1,
   input  logic [2:0] REQ_SELECT_1,
   input  logic       REQ_R_1,
   input  logic [1:0] REQ_RS_1,
   output logic       RESP_VALID0,
   output logic       RESP_VALID1,
   output logic [7:0] RESP_RESULT,
   output logic       RESP_ZERO,
   output logic [7:0] ALU_DATA1,
   output logic [7:0] ALU_DATA2,
   output logic [2:0] ALU_SELECT,
   output logic       ALU_R,
   output logic [1:0] ALU_RS,
   input  logic [7:0] ALU_RESULT,
   input  logic       ALU_ZERO
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       owner_q, owner_d;
   logic [7:0] alu_data1_q, alu_data1_d;
   logic [7:0] alu_data2_q, alu_data2_d;
   logic [2:0] alu_select_q, alu_select_d;
   logic       alu_r_q, alu_r_d;
   logic [1:0] alu_rs_q, alu_rs_d;
   logic [7:0] resp_result_q, resp_result_d;
   logic       resp_zero_q, resp_zero_d;

   logic gnt_any, gnt_sel, accept;

`ifdef ALU_SHARE_FIXED_PRIO_EN
   always_comb begin
      gnt_sel = !REQ_VALID0;
   end
`else
   // ptr_q holds the last-granted requester; a tie goes to the other one.
   logic ptr_q, ptr_d;

   always_comb begin
      if (REQ_VALID0 && REQ_VALID1) gnt_sel = ~ptr_q;
      else                          gnt_sel = !REQ_VALID0;
      ptr_d = accept ? gnt_sel : ptr_q;
   end

   always_ff @(posedge CLK) begin
      if (RESET) ptr_q <= 1'b1;
      else       ptr_q <= ptr_d;
   end
`endif

   always_comb begin
      gnt_any    = (state_q == ST_IDLE) && !RESET && (REQ_VALID0 || REQ_VALID1);
      REQ_READY0 = gnt_any && !gnt_sel;
      REQ_READY1 = gnt_any && gnt_sel;
      accept     = gnt_any;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      owner_d       = owner_q;
      alu_data1_d   = alu_data1_q;
      alu_data2_d   = alu_data2_q;
      alu_select_d  = alu_select_q;
      alu_r_d       = alu_r_q;
      alu_rs_d      = alu_rs_q;
      resp_result_d = resp_result_q;
      resp_zero_d   = resp_zero_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d      = ST_WAIT;
               cnt_d        = 4'(SETTLE_CYCLES);
               owner_d      = gnt_sel;
               alu_data1_d  = gnt_sel ? REQ_DATA1_1  : REQ_DATA1_0;
               alu_data2_d  = gnt_sel ? REQ_DATA2_1  : REQ_DATA2_0;
               alu_select_d = gnt_sel ? REQ_SELECT_1 : REQ_SELECT_0;
               alu_r_d      = gnt_sel ? REQ_R_1      : REQ_R_0;
               alu_rs_d     = gnt_sel ? REQ_RS_1     : REQ_RS_0;
            end
         end
         ST_WAIT: begin
            // Capture on the last settle cycle so DONE presents a stable result.
            if (cnt_q <= 4'd1) begin
               state_d       = ST_DONE;
               resp_result_d = ALU_RESULT;
               resp_zero_d   = ALU_ZERO;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         owner_q       <= 1'b0;
         alu_data1_q   <= 8'd0;
         alu_data2_q   <= 8'd0;
         alu_select_q  <= 3'd0;
         alu_r_q       <= 1'b0;
         alu_rs_q      <= 2'd0;
         resp_result_q <= 8'd0;
         resp_zero_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         owner_q       <= owner_d;
         alu_data1_q   <= alu_data1_d;
         alu_data2_q   <= alu_data2_d;
         alu_select_q  <= alu_select_d;
         alu_r_q       <= alu_r_d;
         alu_rs_q      <= alu_rs_d;
         resp_result_q <= resp_result_d;
         resp_zero_q   <= resp_zero_d;
      end
   end

   always_comb begin
      RESP_VALID0 = (state_q == ST_DONE) && !owner_q;
      RESP_VALID1 = (state_q == ST_DONE) && owner_q;
      RESP_RESULT = resp_result_q;
      RESP_ZERO   = resp_zero_q;
      ALU_DATA1   = alu_data1_q;
      ALU_DATA2   = alu_data2_q;
      ALU_SELECT  = alu_select_q;
      ALU_R       = alu_r_q;
      ALU_RS      = alu_rs_q;
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU hanging off the ALU_* outputs.
module tb_alu_share_arbiter;

   localparam int SETTLE = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       v0, v1, rdy0, rdy1;
   logic [7:0] d1_0, d2_0, d1_1, d2_1;
   logic [2:0] sel_0, sel_1;
   logic       r_0, r_1;
   logic [1:0] rs_0, rs_1;
   logic       rv0, rv1, rzero;
   logic [7:0] rres;
   logic [7:0] a_d1, a_d2, a_res;
   logic [2:0] a_sel;
   logic       a_r, a_zero;
   logic [1:0] a_rs;
   logic [15:0] prod;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
      .CLK(clk), .RESET(rst),
      .REQ_VALID0(v0), .REQ_VALID1(v1), .REQ_READY0(rdy0), .REQ_READY1(rdy1),
      .REQ_DATA1_0(d1_0), .REQ_DATA2_0(d2_0), .REQ_SELECT_0(sel_0), .REQ_R_0(r_0), .REQ_RS_0(rs_0),
      .REQ_DATA1_1(d1_1), .REQ_DATA2_1(d2_1), .REQ_SELECT_1(sel_1), .REQ_R_1(r_1), .REQ_RS_1(rs_1),
      .RESP_VALID0(rv0), .RESP_VALID1(rv1), .RESP_RESULT(rres), .RESP_ZERO(rzero),
      .ALU_DATA1(a_d1), .ALU_DATA2(a_d2), .ALU_SELECT(a_sel), .ALU_R(a_r), .ALU_RS(a_rs),
      .ALU_RESULT(a_res), .ALU_ZERO(a_zero)
   );

   // Behavioural ALU; unused opcodes drive 0xEE so pass-through is observable.
   always_comb begin
      prod = 16'(a_d1) * 16'(a_d2);
      case (a_sel)
         3'b000:  a_res = a_d1;
         3'b001:  a_res = a_d1 + a_d2;
         3'b010:  a_res = a_d1 & a_d2;
         3'b011:  a_res = a_d1 | a_d2;
         3'b100:  a_res = prod[7:0];
         3'b101:  a_res = a_r ? (a_d1 >> a_d2[2:0]) : (a_d1 << a_d2[2:0]);
         default: a_res = 8'hEE;
      endcase
      a_zero = (a_res == 8'h00);
   end

   typedef struct {
      logic       req;
      logic [7:0] d1;
      logic [7:0] d2;
      logic [2:0] sel;
      logic       r;
      logic [1:0] rs;
      logic [7:0] exp_res;
      logic       exp_zero;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " resp_valid"}, {30'd0, rv1, rv0}, 32'd0);
      chk({tag, " resp"}, {23'd0, rzero, rres}, 32'd0);
      chk({tag, " alu_regs"}, {a_d1, a_d2, a_sel, a_r, a_rs, 2'b00}, 32'd0);
   endtask

   task automatic drive_req(input vec_t v);
      if (v.req) begin
         v1 = 1'b1; d1_1 = v.d1; d2_1 = v.d2; sel_1 = v.sel; r_1 = v.r; rs_1 = v.rs;
      end else begin
         v0 = 1'b1; d1_0 = v.d1; d2_0 = v.d2; sel_0 = v.sel; r_0 = v.r; rs_0 = v.rs;
      end
   endtask

   task automatic scramble;
      v0 = 1'b0; v1 = 1'b0;
      d1_0 = ~d1_0; d2_0 = ~d2_0; sel_0 = ~sel_0; r_0 = ~r_0; rs_0 = ~rs_0;
      d1_1 = ~d1_1; d2_1 = ~d2_1; sel_1 = ~sel_1; r_1 = ~r_1; rs_1 = ~rs_1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      logic mine, other;
      lat = 0;
      @(negedge clk);
      drive_req(v);
      #1;
      chk($sformatf("v%0d ready", idx), {30'd0, rdy1, rdy0}, v.req ? 32'd2 : 32'd1);
      @(posedge clk);
      #1;
      scramble();
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         @(negedge clk);
         mine  = v.req ? rv1 : rv0;
         other = v.req ? rv0 : rv1;
         chk($sformatf("v%0d alu_hold c%0d", idx, c), {a_d1, a_d2, a_sel, a_r, a_rs, 2'b00},
             {v.d1, v.d2, v.sel, v.r, v.rs, 2'b00});
         if (mine) begin
            lat = c;
            chk($sformatf("v%0d result", idx), {24'd0, rres}, {24'd0, v.exp_res});
            chk($sformatf("v%0d zero", idx), {31'd0, rzero}, {31'd0, v.exp_zero});
            chk($sformatf("v%0d other_resp", idx), {31'd0, other}, 32'd0);
         end
      end
      chk($sformatf("v%0d latency", idx), lat, SETTLE + 1);
      @(negedge clk);
      chk($sformatf("v%0d pulse_end", idx), {30'd0, rv1, rv0}, 32'd0);
      chk($sformatf("v%0d result_hold", idx), {23'd0, rzero, rres}, {23'd0, v.exp_zero, v.exp_res});
   endtask

   initial begin
      int gnt_who[4];
      int gnt_cyc[4];
      int ng;
      vec_t vr;

      vt[0] = '{1'b0, 8'h05, 8'h03, 3'b001, 1'b0, 2'b00, 8'h08, 1'b0};
      vt[1] = '{1'b1, 8'h80, 8'h80, 3'b001, 1'b0, 2'b00, 8'h00, 1'b1};
      vt[2] = '{1'b0, 8'h07, 8'h06, 3'b100, 1'b0, 2'b00, 8'h2A, 1'b0};
      vt[3] = '{1'b1, 8'h01, 8'h03, 3'b101, 1'b0, 2'b00, 8'h08, 1'b0};
      vt[4] = '{1'b0, 8'hF0, 8'h3C, 3'b010, 1'b0, 2'b00, 8'h30, 1'b0};
      vt[5] = '{1'b1, 8'h00, 8'h00, 3'b011, 1'b0, 2'b00, 8'h00, 1'b1};
      vt[6] = '{1'b0, 8'hA5, 8'h00, 3'b000, 1'b0, 2'b00, 8'hA5, 1'b0};
      vt[7] = '{1'b1, 8'h80, 8'h03, 3'b101, 1'b1, 2'b10, 8'h10, 1'b0};
      vt[8] = '{1'b0, 8'h12, 8'h34, 3'b110, 1'b1, 2'b01, 8'hEE, 1'b0};

      rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
      d1_0 = 0; d2_0 = 0; sel_0 = 0; r_0 = 0; rs_0 = 0;
      d1_1 = 0; d2_1 = 0; sel_1 = 0; r_1 = 0; rs_1 = 0;

      // Reset state, with a valid request that must not be acknowledged.
      repeat (2) @(negedge clk);
      v0 = 1'b1;
      #1;
      chk("reset ready", {30'd0, rdy1, rdy0}, 32'd0);
      chk_reset_outputs("reset");
      v0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vt[i], i);

      // Contention: both valid from reset release.
      @(negedge clk);
      rst = 1'b1;
      drive_req(vt[0]);
      drive_req(vt[1]);
      @(negedge clk);
      rst = 1'b0;
      ng = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         #1;
         if (rdy0 && rdy1) chk("dual_ready", 32'd1, 32'd0);
         if (rdy0 || rdy1) begin
            gnt_who[ng] = rdy1 ? 1 : 0;
            gnt_cyc[ng] = c;
            ng++;
         end
         @(negedge clk);
      end
      chk("contention grants", ng, 4);
      for (int i = 0; i < ng; i++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
         chk($sformatf("grant%0d who", i), gnt_who[i], 0);
`else
         chk($sformatf("grant%0d who", i), gnt_who[i], i % 2);
`endif
         if (i > 0) chk($sformatf("grant%0d spacing", i), gnt_cyc[i] - gnt_cyc[i-1], SETTLE + 2);
      end
      v0 = 1'b0; v1 = 1'b0;
      repeat (SETTLE + 3) @(negedge clk);

      // Reset in the second WAIT cycle discards the operation.
      vr = vt[2];
      drive_req(vr);
      #1;
      chk("rst_mid ready", {30'd0, rdy1, rdy0}, 32'd1);
      @(posedge clk);
      #1;
      scramble();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid pre", {30'd0, rv1, rv0}, 32'd0);
      @(negedge clk);
      chk_reset_outputs("rst_mid");
      rst = 1'b0;
      for (int c = 0; c < SETTLE + 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst_mid no_resp c%0d", c), {30'd0, rv1, rv0}, 32'd0);
      end
      run_vec(vt[3], 9);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
